// File: rtl/cache_pkg.sv
// Shared types for the LRU age tracker.
// Operation encoding, FSM states and the age-field width helper.
package cache_pkg;

  typedef enum logic [1:0] {
    HIT   = 2'd0,
    FILL  = 2'd1,
    INVAL = 2'd2,
    RSVD  = 2'd3
  } lru_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2
  } lru_state_e;

  function automatic int age_w(input int assoc);
    return $clog2(assoc);
  endfunction

endpackage

// File: rtl/lru_age_next.sv
// Next-age computation for one set plus LRU victim search.
// Ages are a permutation of 0..ASSOC-1; 0 is LRU, ASSOC-1 is MRU.
module lru_age_next
  import cache_pkg::*;
#(
  parameter int ASSOC = 8,
  localparam int W = age_w(ASSOC)
) (
  input  logic [ASSOC*W-1:0] i_ages,
  input  lru_op_e            i_op,
  input  logic [W-1:0]       i_way,
  output logic [ASSOC*W-1:0] o_ages,
  output logic [W-1:0]       o_victim
);

  localparam logic [W-1:0] MRU = W'(ASSOC - 1);

  logic [W-1:0] w_tgt;
  logic [W-1:0] w_tage;
  logic         w_promote;
  logic         w_demote;

  always_comb begin
    o_victim = '0;
    for (int i = 0; i < ASSOC; i++) begin
      if (i_ages[i*W +: W] == '0)
        o_victim = W'(i);
    end
  end

  // FILL promotes the victim exactly like a HIT on it
  assign w_tgt     = (i_op == FILL) ? o_victim : i_way;
  assign w_tage    = i_ages[w_tgt*W +: W];
  assign w_promote = (i_op == HIT) || (i_op == FILL);
  assign w_demote  = (i_op == INVAL);

  always_comb begin
    o_ages = i_ages;
    for (int i = 0; i < ASSOC; i++) begin
      unique case (1'b1)
        w_promote: begin
          if (W'(i) == w_tgt)
            o_ages[i*W +: W] = MRU;
          else if (i_ages[i*W +: W] > w_tage)
            o_ages[i*W +: W] = i_ages[i*W +: W] - W'(1);
        end
        w_demote: begin
          if (W'(i) == w_tgt)
            o_ages[i*W +: W] = '0;
          else if (i_ages[i*W +: W] < w_tage)
            o_ages[i*W +: W] = i_ages[i*W +: W] + W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lru_update.sv
// Per-set LRU age tracker: IDLE -> READ -> UPDATE, one response per request.
// Set ages live in a register array; minimum spacing of 3 cycles avoids bypass.
module lru_update
  import cache_pkg::*;
#(
  parameter int ASSOC = 8,
  parameter int SETS  = 16,
  localparam int W  = age_w(ASSOC),
  localparam int SW = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SW-1:0]      req_set,
  input  logic [W-1:0]       req_way,
  input  logic [1:0]         req_op,
  output logic               resp_valid,
  output logic [W-1:0]       resp_way,
  output logic [ASSOC*W-1:0] resp_lru_bits
);

  typedef struct packed {
    logic [SW-1:0] set;
    logic [W-1:0]  way;
    lru_op_e       op;
  } req_t;

  lru_state_e r_state;
  lru_state_e w_next;

  req_t               r_req;
  logic [ASSOC*W-1:0] r_ages;
  logic [ASSOC*W-1:0] r_mem [SETS];
  logic               r_resp_valid;
  logic [W-1:0]       r_resp_way;
  logic [ASSOC*W-1:0] r_resp_bits;

  logic               w_accept;
  logic [ASSOC*W-1:0] w_new;
  logic [W-1:0]       w_victim;
  logic [W-1:0]       w_resp_way;

  assign req_ready     = (r_state == IDLE);
  assign w_accept      = req_valid && req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_way      = r_resp_way;
  assign resp_lru_bits = r_resp_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = READ;
      READ:    w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  lru_age_next #(
    .ASSOC(ASSOC)
  ) u_next (
    .i_ages  (r_ages),
    .i_op    (r_req.op),
    .i_way   (r_req.way),
    .o_ages  (w_new),
    .o_victim(w_victim)
  );

  assign w_resp_way = (r_req.op == FILL) ? w_victim : r_req.way;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req        <= '0;
      r_ages       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_way   <= '0;
      r_resp_bits  <= '0;
      for (int s = 0; s < SETS; s++)
        for (int i = 0; i < ASSOC; i++)
          r_mem[s][i*W +: W] <= W'(i);
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept)
        r_req <= '{set: req_set, way: req_way, op: lru_op_e'(req_op)};
      if (r_state == READ)
        r_ages <= r_mem[r_req.set];
      if (r_state == UPDATE) begin
        r_mem[r_req.set] <= w_new;
        r_resp_valid     <= 1'b1;
        r_resp_way       <= w_resp_way;
        r_resp_bits      <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_lru_update.sv
// Directed bench for lru_update with ASSOC=4, SETS=4.
// Ages packed as {way3,way2,way1,way0}, 2 bits each.
module tb_lru_update;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_set;
  logic [1:0] req_way;
  logic [1:0] req_op;
  logic       resp_valid;
  logic [1:0] resp_way;
  logic [7:0] resp_bits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lru_update #(
    .ASSOC(4),
    .SETS (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_set      (req_set),
    .req_way      (req_way),
    .req_op       (req_op),
    .resp_valid   (resp_valid),
    .resp_way     (resp_way),
    .resp_lru_bits(resp_bits)
  );

  function automatic logic [7:0] pk(input int a0, a1, a2, a3);
    return {a3[1:0], a2[1:0], a1[1:0], a0[1:0]};
  endfunction

  // every write-back must leave a permutation of 0..3
  always @(negedge clk) begin
    logic [3:0] seen;
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      seen = '0;
      for (int i = 0; i < 4; i++) seen[resp_bits[i*2 +: 2]] = 1'b1;
      checks++;
      if (seen !== 4'hf) begin
        errors++;
        $display("FAIL perm: ages %h not a permutation", resp_bits);
      end
    end
  end

  // lat counts negedges after the accepting edge; 3 means cycle T+2
  task automatic issue(input int set, way, op,
                       output logic [1:0] rway,
                       output logic [7:0] rbits,
                       output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_set   = set[1:0];
    req_way   = way[1:0];
    req_op    = op[1:0];
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    rway  = resp_way;
    rbits = resp_bits;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_way !== 2'd0 || resp_bits !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got v=%b w=%0d b=%h want 0 0 00",
               resp_valid, resp_way, resp_bits);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] w;
    logic [7:0] b;
    int         lat;
    issue(0, 0, 1, w, b, lat);
    checks++;
    if (lat !== 3 || w !== 2'd0 || b !== pk(3, 0, 1, 2)) begin
      errors++;
      $display("FAIL fill1: lat=%0d w=%0d b=%h want 3 0 %h",
               lat, w, b, pk(3, 0, 1, 2));
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: resp_valid=%b want 0", resp_valid);
    end
    issue(0, 2, 0, w, b, lat);
    checks++;
    if (lat !== 3 || w !== 2'd2 || b !== pk(2, 0, 3, 1)) begin
      errors++;
      $display("FAIL hit2: lat=%0d w=%0d b=%h want 3 2 %h",
               lat, w, b, pk(2, 0, 3, 1));
    end
    issue(0, 3, 1, w, b, lat);
    checks++;
    if (w !== 2'd1 || b !== pk(1, 3, 2, 0)) begin
      errors++;
      $display("FAIL fill2: w=%0d b=%h want 1 %h", w, b, pk(1, 3, 2, 0));
    end
    issue(0, 2, 2, w, b, lat);
    checks++;
    if (w !== 2'd2 || b !== pk(2, 3, 0, 1)) begin
      errors++;
      $display("FAIL inval2: w=%0d b=%h want 2 %h", w, b, pk(2, 3, 0, 1));
    end
    issue(0, 0, 1, w, b, lat);
    checks++;
    if (w !== 2'd2 || b !== pk(1, 2, 3, 0)) begin
      errors++;
      $display("FAIL fill3: w=%0d b=%h want 2 %h", w, b, pk(1, 2, 3, 0));
    end
  endtask

  task automatic test_noop();
    logic [1:0] w;
    logic [7:0] b;
    int         lat;
    issue(1, 3, 0, w, b, lat);
    checks++;
    if (lat !== 3 || w !== 2'd3 || b !== pk(0, 1, 2, 3)) begin
      errors++;
      $display("FAIL hit_mru: lat=%0d w=%0d b=%h want 3 3 %h",
               lat, w, b, pk(0, 1, 2, 3));
    end
    issue(0, 1, 3, w, b, lat);
    checks++;
    if (w !== 2'd1 || b !== pk(1, 2, 3, 0)) begin
      errors++;
      $display("FAIL set0_kept: w=%0d b=%h want 1 %h", w, b, pk(1, 2, 3, 0));
    end
    issue(3, 0, 2, w, b, lat);
    checks++;
    if (w !== 2'd0 || b !== pk(0, 1, 2, 3)) begin
      errors++;
      $display("FAIL inval_lru: w=%0d b=%h want 0 %h", w, b, pk(0, 1, 2, 3));
    end
  endtask

  task automatic test_back_to_back();
    int resps = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_set   = 2'd3;
    req_way   = 2'd0;
    req_op    = 2'd0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (req_ready !== (i % 3 == 0)) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", i, req_ready, i % 3 == 0);
      end
      if (resp_valid) resps++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (resp_valid) resps++;
    checks++;
    if (resps !== 4 || resp_bits !== pk(3, 0, 1, 2)) begin
      errors++;
      $display("FAIL b2b_resps: got %0d b=%h want 4 %h", resps, resp_bits,
               pk(3, 0, 1, 2));
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] w;
    logic [7:0] b;
    int         lat;
    int         seen = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_set   = 2'd0;
    req_way   = 2'd0;
    req_op    = 2'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort: got %0d responses want 0", seen);
    end
    for (int s = 0; s < 4; s++) begin
      issue(s, 0, 3, w, b, lat);
      checks++;
      if (lat !== 3 || b !== pk(0, 1, 2, 3)) begin
        errors++;
        $display("FAIL reinit[%0d]: lat=%0d b=%h want 3 %h",
                 s, lat, b, pk(0, 1, 2, 3));
      end
    end
  endtask

  initial begin
    req_valid = 1'b0;
    req_set   = '0;
    req_way   = '0;
    req_op    = '0;
    test_reset();
    test_sequence();
    test_noop();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lru_update.md
LRU_UPDATE -- requirements
Module: lru_update

Interface
REQ-001 SHALL have parameter ASSOC, default 8, meaning ways per set (power of two, 2..16).
REQ-002 SHALL have parameter SETS, default 16, meaning number of sets tracked (power of two).
REQ-003 SHALL define W = clog2(ASSOC) as the age-field width; way i's age SHALL occupy bits [i*W +: W] of a packed ASSOC*W vector.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  access request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_set  in  clog2(SETS)  target set index.
REQ-009 req_way  in  W  accessed way (ignored for FILL).
REQ-010 req_op  in  2  operation: 0 HIT, 1 FILL, 2 INVAL, 3 reserved (treated as no-op, still responds).
REQ-011 resp_valid  out  1  one-cycle pulse, request complete.
REQ-012 resp_way  out  W  way updated: victim for FILL, req_way otherwise.
REQ-013 resp_lru_bits  out  ASSOC*W  packed ages of the set after the update.

Function
REQ-014 Each age SHALL be 0 for LRU and ASSOC-1 for MRU; the ages in a set SHALL always form a permutation of 0..ASSOC-1.
REQ-015 The FSM SHALL have states IDLE, READ, UPDATE: IDLE->READ on req_valid&&req_ready; READ->UPDATE unconditionally; UPDATE->IDLE unconditionally.
REQ-016 req_ready SHALL be 1 only in IDLE; inputs SHALL be captured on the accepting edge; req_valid outside IDLE SHALL be ignored.
REQ-017 READ SHALL load the set's ages into a working register; UPDATE SHALL compute, write back and respond.
REQ-018 resp_valid SHALL assert exactly 2 cycles after the accepting edge (accepted at T, pulse during cycle T+2), with no backpressure.
REQ-019 HIT of way w with age a: every way with age > a SHALL decrement, and w SHALL become ASSOC-1.
REQ-020 FILL: the victim SHALL be the way with age 0; it SHALL be reported on resp_way and then promoted as for HIT.
REQ-021 INVAL of way w with age a: every way with age < a SHALL increment, and w SHALL become 0.
REQ-022 A HIT of a way that is already MRU, or an INVAL of a way that is already LRU, SHALL leave the ages unchanged and still respond.
REQ-023 Back-to-back requests to the same set SHALL see the prior write-back; the minimum spacing of 3 cycles guarantees this without bypass.
REQ-024 resp_way and resp_lru_bits SHALL hold their values until the next UPDATE.

Reset
REQ-025 Reset assertion SHALL drive the FSM to IDLE, resp_valid to 0, resp_way to 0 and resp_lru_bits to 0, and SHALL abort any in-flight request with no response.
REQ-026 Reset SHALL initialise every set so that way i has age i (way 0 = LRU, way ASSOC-1 = MRU).
REQ-027 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-028 Package cache_pkg SHALL hold the lru_op_e enum (HIT, FILL, INVAL, RSVD) and the age-width constant/function.
REQ-029 The combinational next-age and victim-find logic SHALL live in one sub-module, lru_age_next (inputs: ages, op, way; outputs: new ages, victim).
REQ-030 Set storage SHALL be a register array of SETS x ASSOC*W bits.

Verification (ASSOC=4, SETS=4; ages listed as way0..way3)
REQ-031 Reset, then FILL on set 0 -> resp_way=0, ages 3,0,1,2, resp_valid exactly 2 cycles after acceptance.
REQ-032 Continuing: HIT on way 2 -> ages 2,0,3,1; then FILL -> resp_way=1, ages 1,3,2,0.
REQ-033 Continuing: INVAL on way 2 (age 2) -> ages 2,3,0,1; then FILL -> resp_way=2.
REQ-034 HIT on way 3 of untouched set 1 (already MRU) -> ages stay 0,1,2,3; set 0 is unaffected.
REQ-035 req_valid held high continuously -> accepts every 3rd cycle, req_ready low in READ/UPDATE, one resp per accept.
REQ-036 rst_n asserted during READ -> no resp_valid pulse; all sets return to 0,1,2,3.
REQ-037 The permutation invariant SHALL be checked by assertion on every write-back in every scenario.
